irq_prio_ctrl: RTL
==================

Name: irq_prio_ctrl

Overview:
Sequential interrupt controller that shares one service channel between 8 active-low requesters. Requests are synchronised, edge-latched into a pending register, masked, and granted one at a time by priority encoding, with the highest index winning. Each grant is held until the service side acknowledges it or a timeout expires. It drives active-low GS/EO-style status outputs so it can replace a bare 8-to-3 priority encoder in existing datapaths.

Parameters:
N_REQ, 8, number of requesters; fixed at 8 (vec is 3 bits).
SYNC_STAGES, 2, synchroniser depth on req_n; legal values 2..3.
TIMEOUT_CYC, 16, cycles in REQ without ack before the grant is withdrawn; 0 disables the timeout.
GAP_CYC, 1, idle cycles forced after each ack before the next grant; legal values 0..15.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
en_n  in  1  active-low enable; high suspends granting.
req_n  in  8  active-low asynchronous request lines; falling edge = event.
mask  in  8  1 = line masked from grant; pending capture continues.
ack  in  1  service side accepts the current vec; single-cycle pulse.
irq  out  1  grant valid; vec is stable while high.
vec  out  3  binary index of the granted line (not inverted).
gs_n  out  1  0 when en_n=0 and any unmasked pending bit is set.
eo_n  out  1  0 when en_n=0 and no unmasked pending bit is set.
pending  out  8  latched events awaiting service.
timeout  out  1  one-cycle pulse when a grant is withdrawn unacknowledged.

Behaviour:
- Reset (async assert, sync-released internally): synchroniser and edge-detect flops = 1; pending=0; state=IDLE; irq=0; vec=0; timeout=0; counters=0; gs_n=1; eo_n=1.
- Capture: pending[i] sets on a synchronised 1->0 transition of req_n[i]. With defaults the bit is visible 3 rising edges after the input falls (SYNC_STAGES+1). Capture is independent of en_n and mask.
- Set/clear collision: if a new event on line i lands in the cycle pending[i] is cleared by ack, set wins. Repeated edges while pending merge into one event.
- FSM states: IDLE, REQ, GAP.
- IDLE: if en_n=0 and (pending & ~mask) != 0, load vec with the winner and go to REQ. irq asserts on the next edge, so total latency from req_n falling to irq high is SYNC_STAGES+2 edges.
- REQ: irq=1 and vec is frozen; mask changes do not revoke the grant.
  - ack=1: clear pending[vec]; go to GAP (or IDLE if GAP_CYC=0).
  - Timeout count reaches TIMEOUT_CYC-1 with ack=0: go to IDLE, pulse timeout, keep pending[vec].
  - ack and the timeout threshold in the same cycle: ack wins, no timeout pulse.
- GAP: irq=0; count GAP_CYC cycles, then go to IDLE.
- en_n=1 in any state: next state is IDLE, irq=0, counters cleared, pending retained; gs_n=eo_n=1.
- ack outside REQ is ignored.
- gs_n and eo_n are combinational from registered pending, mask and en_n.

Optional Feature:
Macro IRQ_PRIO_RR_EN.
- Defined: rotating priority. A last-grant pointer (reset 0) updates on ack. The search starts at (last+N_REQ-1) mod N_REQ and proceeds downward with wrap, so the first search after reset starts at index 7.
- Undefined: fixed priority, highest index wins; the pointer is not instantiated.

Decomposition:
- Package irq_prio_pkg: state enum {IDLE, REQ, GAP}; VEC_W=3; N_REQ constant.
- Sub-module prio_enc8: combinational 8-to-3 encoder with a start-index input and a found flag. Tie the start index to 7 when the macro is undefined.

Test Plan:
- Reset mid-REQ (rst_n low while irq=1) -> irq=0, pending=0, gs_n=1 immediately; no glitch on release.
- req_n[2] and req_n[5] fall in the same cycle, en_n=0, mask=0 -> irq after 4 edges with vec=5; ack -> GAP 1 cycle -> vec=2; ack -> pending=0, eo_n=0.
- mask=8'h80, req_n[7] and req_n[1] fall -> vec=1; after ack, pending=8'h80, gs_n=1, eo_n=0; clearing mask -> vec=7.
- TIMEOUT_CYC=16, no ack -> irq high for exactly 16 cycles, then a timeout pulse of 1 cycle; pending bit kept and regranted after IDLE. Repeat with ack on cycle 16 -> no timeout pulse.
- en_n=1 during REQ -> irq drops next edge and pending is unchanged; en_n=0 -> the same vec is regranted.
- IRQ_PRIO_RR_EN, lines 6 and 3 re-requested after every ack -> grants alternate 6,3,6,3.

Source files
------------

// File: rtl/irq_prio_pkg.sv
// -----------------------------------------------------------------------------
// irq_prio_pkg
// Shared constants and types for the irq_prio_ctrl interrupt controller.
//   N_REQ  : number of requesters (fixed at 8)
//   VEC_W  : width of the granted-line index
//   state_e: grant FSM states
//   rr_start: first index searched by the rotating-priority encoder
// -----------------------------------------------------------------------------
package irq_prio_pkg;

  localparam int N_REQ = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Search begins one below the last serviced line; 3-bit arithmetic wraps
  // 0 -> 7, so a pointer reset to 0 starts the very first search at 7.
  function automatic logic [VEC_W-1:0] rr_start(input logic [VEC_W-1:0] last);
    return last - VEC_W'(1);
  endfunction

endpackage

// File: rtl/irq_prio_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_prio_ctrl_if
// Service-channel handshake between the controller and its service side.
//   irq     : grant valid, vec stable while high      (controller -> service)
//   vec     : binary index of the granted line        (controller -> service)
//   timeout : one-cycle pulse on unacknowledged grant (controller -> service)
//   ack     : single-cycle accept of current vec      (service -> controller)
// Modports: master = controller side, slave = service side.
// -----------------------------------------------------------------------------
interface irq_prio_ctrl_if;
  import irq_prio_pkg::*;

  logic             irq;
  logic [VEC_W-1:0] vec;
  logic             timeout;
  logic             ack;

  modport master (output irq, output vec, output timeout, input ack);
  modport slave  (input irq, input vec, input timeout, output ack);

endinterface

// File: rtl/prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational 8-to-3 priority encoder with a programmable start index.
// The search begins at start_i and walks downward, wrapping 0 -> 7; the first
// set bit met wins. With start_i = 7 this is a plain highest-index-wins
// encoder.
//   req_i   : candidate lines (1 = requesting)
//   start_i : index searched first
//   found_o : at least one candidate set
//   idx_o   : winning index (0 when found_o = 0)
// -----------------------------------------------------------------------------
module prio_enc8
  import irq_prio_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [VEC_W-1:0] start_i,
  output logic             found_o,
  output logic [VEC_W-1:0] idx_o
);

  logic [VEC_W-1:0] j;

  // Iterate from the farthest search position toward start_i so the
  // closest hit overwrites earlier ones and ends up as the winner.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = start_i - VEC_W'(k);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// -----------------------------------------------------------------------------
// irq_prio_ctrl
// Sequential interrupt controller sharing one service channel between 8
// active-low requesters. Requests are synchronised, falling-edge latched into
// a pending register, masked and granted one at a time. A grant is held until
// ack or until TIMEOUT_CYC cycles pass. GS/EO-style status outputs allow it to
// stand in for a bare 8-to-3 priority encoder.
//
// Optional build macro: IRQ_PRIO_RR_EN
//   defined   -> rotating priority; last-grant pointer updated on ack
//   undefined -> fixed priority, highest index wins
//
// Parameters:
//   SYNC_STAGES : synchroniser depth on req_n (2..3)
//   TIMEOUT_CYC : REQ cycles without ack before withdrawal (0 = never)
//   GAP_CYC     : idle cycles forced after each ack (0..15)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (released synchronously)
//   en_n        : active-low enable; high suspends granting
//   req_n[7:0]  : active-low asynchronous request lines
//   mask[7:0]   : 1 = line excluded from grant (capture continues)
//   bus         : irq/vec/timeout/ack service handshake (master side)
//   gs_n, eo_n  : group-select / enable-out status, active low
//   pending     : latched events awaiting service
// -----------------------------------------------------------------------------
module irq_prio_ctrl
  import irq_prio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int GAP_CYC     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_n,
  input  logic [N_REQ-1:0]      req_n,
  input  logic [N_REQ-1:0]      mask,
  irq_prio_ctrl_if.master       bus,
  output logic                  gs_n,
  output logic                  eo_n,
  output logic [N_REQ-1:0]      pending
);

  localparam int TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     GMAX = 4'(GAP_CYC - 1);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, deasserts two edges after rst_n rises so
  // every flop leaves reset on the same clean edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Request synchroniser and falling-edge detect. Flops reset to 1 (idle
  // level) so release of reset with req_n high produces no event.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q;
  logic [N_REQ-1:0]                  prev_q;
  logic [N_REQ-1:0]                  req_s;
  logic [N_REQ-1:0]                  fall;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_n};
      prev_q <= req_s;
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~req_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             irq_q, irq_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic             ack_clr;
  logic [N_REQ-1:0] clr_mask;

  logic [N_REQ-1:0] cand;
  logic [VEC_W-1:0] start;
  logic             found;
  logic [VEC_W-1:0] win;

  assign cand = pending_q & ~mask;

`ifdef IRQ_PRIO_RR_EN
  logic [VEC_W-1:0] last_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)   last_q <= '0;
    else if (ack_clr) last_q <= vec_q;
  end

  assign start = rr_start(last_q);
`else
  assign start = VEC_W'(N_REQ - 1);
`endif

  prio_enc8 u_enc (
    .req_i   (cand),
    .start_i (start),
    .found_o (found),
    .idx_o   (win)
  );

  // ---------------------------------------------------------------------------
  // Grant FSM, next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    timeout_d = 1'b0;
    ack_clr   = 1'b0;

    if (en_n) begin
      // Suspended: any grant is withdrawn, pending stays untouched. An ack
      // arriving in this cycle is not honoured since the grant is gone.
      state_d = IDLE;
      tcnt_d  = '0;
      gcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tcnt_d = '0;
          gcnt_d = '0;
          if (found) begin
            vec_d   = win;
            state_d = REQ;
          end
        end
        REQ: begin
          if (bus.ack) begin
            // ack has priority over a timeout landing in the same cycle
            ack_clr = 1'b1;
            tcnt_d  = '0;
            state_d = (GAP_CYC == 0) ? IDLE : GAP;
          end else if (TIMEOUT_CYC != 0) begin
            if (tcnt_q == TMAX) begin
              state_d   = IDLE;
              timeout_d = 1'b1;
              tcnt_d    = '0;
            end else begin
              tcnt_d = tcnt_q + TCW'(1);
            end
          end
        end
        GAP: begin
          if (gcnt_q == GMAX) begin
            state_d = IDLE;
            gcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    irq_d = (state_d == REQ);
  end

  // A new edge on the line being acknowledged re-sets it: set beats clear.
  always_comb begin
    clr_mask = '0;
    if (ack_clr) clr_mask[vec_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | fall;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
      irq_q     <= 1'b0;
      timeout_q <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      tcnt_q    <= tcnt_d;
      gcnt_q    <= gcnt_d;
      irq_q     <= irq_d;
      timeout_q <= timeout_d;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. irq is its own flop so it cannot glitch on state decode.
  // ---------------------------------------------------------------------------
  assign bus.irq     = irq_q;
  assign bus.vec     = vec_q;
  assign bus.timeout = timeout_q;
  assign pending     = pending_q;

  assign gs_n = ~(~en_n &  (|cand));
  assign eo_n = ~(~en_n & ~(|cand));

endmodule
